// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: select codes, ALUOp
// encodings, funct3 values of interest and the controller state type.
package alu_issue_ctrl_pkg;

    localparam int DATA_W_DEF = 12;

    // ALU select codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] OP_LDST   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // R-type funct3 values that map to a supported operation
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response bundle between the decode stage and the issue controller.
// master = decode/consumer side, slave = issue controller.
interface alu_issue_ctrl_if
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;

    modport master (
        output in_valid, alu_op, funct3, funct7_5, op_a, op_b, res_ready,
        input  in_ready, res_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7_5, op_a, op_b, res_ready,
        output in_ready, res_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational ALU control decode: ALUOp/funct3/funct7[5] -> select code.
// Unsupported combinations fall back to ADD and raise illegal.
module alu_issue_ctrl_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] sel_o,
    output logic       illegal_o
);

    // Map the instruction slice onto an ALU select code
    always_comb begin
        sel_o     = ALU_ADD;
        illegal_o = 1'b0;
        case (alu_op_i)
            OP_LDST:   sel_o = ALU_ADD;
            OP_BRANCH: sel_o = ALU_SUB;
            OP_RTYPE: begin
                case (funct3_i)
                    F3_ADDSUB: sel_o = funct7_5_i ? ALU_SUB : ALU_ADD;
                    F3_AND:    sel_o = ALU_AND;
                    F3_OR:     sel_o = ALU_OR;
                    default:   illegal_o = 1'b1;
                endcase
            end
            OP_RSVD:   illegal_o = 1'b1;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issuer for the external combinational ALU. Accepts a request
// in IDLE, lets the ALU settle for one cycle on registered inputs (EXEC),
// then presents the captured result until the consumer takes it (RESP).
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [3:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              ill_q, ill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        dec_sel;
    logic              dec_illegal;
    logic              accept;
    logic              complete;

    alu_issue_ctrl_decode u_decode (
        .alu_op_i   (bus.alu_op),
        .funct3_i   (bus.funct3),
        .funct7_5_i (bus.funct7_5),
        .sel_o      (dec_sel),
        .illegal_o  (dec_illegal)
    );

    // Requests are only taken in IDLE; results only retire in RESP
    assign accept   = (state_q == ST_IDLE) && bus.in_valid;
    assign complete = (state_q == ST_RESP) && bus.res_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: EXEC always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (complete) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
            ST_IDLE: bus.in_ready  = 1'b1;
            ST_RESP: bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: operands on accept, result at end of EXEC, count on retire
    always_comb begin
        sel_d  = sel_q;
        a_d    = a_q;
        b_d    = b_q;
        ill_d  = ill_q;
        res_d  = res_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        if (accept) begin
            sel_d = dec_sel;
            a_d   = bus.op_a;
            b_d   = bus.op_b;
            ill_d = dec_illegal;
        end
        if (state_q == ST_EXEC) begin
            res_d  = alu_out;
            zero_d = (alu_out == '0);
        end
        if (complete) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= ALU_ADD;
            a_q    <= '0;
            b_q    <= '0;
            ill_q  <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sel_q  <= sel_d;
            a_q    <= a_d;
            b_q    <= b_d;
            ill_q  <= ill_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

    assign alu_sel     = sel_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign bus.result  = res_q;
    assign bus.zero    = zero_q;
    assign bus.illegal = ill_q;
    assign op_count    = cnt_q;

endmodule
